// File: rtl/input_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_pkg
// Brief    : Shared types and constants for the board input processing blocks.
// Revision : 1.0
// ============================================================================
package input_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        TIMING   = 2'd1,
        COMMIT   = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    localparam int   DEBOUNCE_DEFAULT = 50;
    localparam logic EVT_RELEASE      = 1'b0;
    localparam logic EVT_PRESS        = 1'b1;

endpackage
`default_nettype wire

// File: rtl/debounce_timer.sv
`default_nettype none
// ============================================================================
// Module   : debounce_timer
// Brief    : Shared stability counter; done flags the last cycle of the window.
// Revision : 1.0
// ============================================================================
module debounce_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             power,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_last;

    assign w_last = limit - CNT_W'(1);
    assign done   = (r_count == w_last);

    // Holds at limit-1 so a stalled caller never sees the count wrap.
    always_ff @(posedge clk or negedge power) begin
        if (!power) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !done) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : button_scheduler
// Brief    : Round-robin debouncer sharing one timer across N_BTN buttons,
//            emitting one press/release event per committed level change.
// Revision : 1.0
// ============================================================================
module button_scheduler
    import input_pkg::*;
#(
    parameter int N_BTN           = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 16,
    parameter int ID_W            = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             power,
    input  logic [N_BTN-1:0] bt,
    output logic [N_BTN-1:0] button,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_press,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_bs;
    logic [N_BTN-1:0] r_button;
    logic             r_evt_valid;
    logic [ID_W-1:0]  r_evt_id;
    logic             r_evt_press;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [ID_W-1:0]  r_cid;
    logic [ID_W-1:0]  w_cid_nxt;
    logic             r_cval;
    logic             w_cval_nxt;

    logic             w_clear;
    logic             w_enable;
    logic             w_done;
    logic             w_commit;
    logic             w_ack;

    always_ff @(posedge clk or negedge power) begin
        if (!power) begin
            r_sync1 <= '0;
            r_bs    <= '0;
        end else begin
            r_sync1 <= bt;
            r_bs    <= r_sync1;
        end
    end

    debounce_timer #(
        .CNT_W  (CNT_W)
    ) u_timer (
        .clk    (clk),
        .power  (power),
        .clear  (w_clear),
        .enable (w_enable),
        .limit  (c_LIMIT),
        .done   (w_done)
    );

    assign w_ack = r_evt_valid && evt_ready;

    // Pointer wraps for free because N_BTN is a power of two.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cid_nxt   = r_cid;
        w_cval_nxt  = r_cval;
        w_clear     = 1'b0;
        w_enable    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            SCAN: begin
                if (r_bs[r_ptr] != r_button[r_ptr]) begin
                    w_cid_nxt   = r_ptr;
                    w_cval_nxt  = r_bs[r_ptr];
                    w_clear     = 1'b1;
                    w_state_nxt = TIMING;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            TIMING: begin
                if (r_bs[r_cid] != r_cval) begin
                    w_ptr_nxt   = r_cid + 1'b1;
                    w_state_nxt = SCAN;
                end else if (w_done) begin
                    w_state_nxt = COMMIT;
                end else begin
                    w_enable = 1'b1;
                end
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (w_ack) begin
                    w_ptr_nxt   = r_cid + 1'b1;
                    w_state_nxt = SCAN;
                end
            end
            default: begin
                w_state_nxt = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge power) begin
        if (!power) begin
            r_state <= SCAN;
            r_ptr   <= '0;
            r_cid   <= '0;
            r_cval  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cid   <= w_cid_nxt;
            r_cval  <= w_cval_nxt;
        end
    end

    always_ff @(posedge clk or negedge power) begin
        if (!power) begin
            r_button    <= '0;
            r_evt_valid <= 1'b0;
            r_evt_id    <= '0;
            r_evt_press <= EVT_RELEASE;
        end else if (w_commit) begin
            r_button[r_cid] <= r_cval;
            r_evt_valid     <= 1'b1;
            r_evt_id        <= r_cid;
            r_evt_press     <= r_cval;
        end else if (r_state == WAIT_ACK && w_ack) begin
            r_evt_valid <= 1'b0;
        end
    end

    assign button    = r_button;
    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign evt_press = r_evt_press;
    assign busy      = (r_state != SCAN);

endmodule
`default_nettype wire

// File: tb/tb_button_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_scheduler
// Brief    : Directed bench with a rule-based event model for button_scheduler.
// Revision : 1.0
// ============================================================================
module tb_button_scheduler;

    localparam int N = 8;
    localparam int D = 4;

    typedef struct packed {
        logic [2:0] id;
        logic       press;
    } ev_t;

    logic       clk   = 1'b0;
    logic       power = 1'b1;
    logic [7:0] bt    = '0;
    logic       evt_ready = 1'b1;
    logic [7:0] button;
    logic       evt_valid;
    logic [2:0] evt_id;
    logic       evt_press;
    logic       busy;

    logic [7:0] bt50 = '0;
    logic       evt_ready50 = 1'b1;
    logic [7:0] button50;
    logic       evt_valid50;
    logic [2:0] evt_id50;
    logic       evt_press50;
    logic       busy50;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    button_scheduler #(
        .N_BTN(N), .DEBOUNCE_CYCLES(D), .CNT_W(16), .ID_W(3)
    ) u_dut (
        .clk(clk), .power(power), .bt(bt), .button(button),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_press(evt_press), .busy(busy)
    );

    button_scheduler #(
        .N_BTN(N)
    ) u_dut50 (
        .clk(clk), .power(power), .bt(bt50), .button(button50),
        .evt_valid(evt_valid50), .evt_ready(evt_ready50), .evt_id(evt_id50),
        .evt_press(evt_press50), .busy(busy50)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Two-flop view of the pins, as the scheduler should see them.
    logic [7:0] m_s1, m_bs;
    always @(posedge clk or negedge power) begin
        if (!power) begin
            m_s1 <= '0;
            m_bs <= '0;
        end else begin
            m_s1 <= bt;
            m_bs <= m_s1;
        end
    end

    logic [7:0] hist [0:15];
    logic [7:0] m_btn;
    logic       p_valid, p_ready, p_press;
    logic [2:0] p_id;
    ev_t        exp_q[$];

    always @(negedge clk) begin
        ev_t e;
        for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = m_bs;
        if (!power) begin
            for (int k = 0; k < 16; k++) hist[k] = '0;
            m_btn   = '0;
            p_valid = 1'b0;
            p_ready = 1'b0;
            p_id    = '0;
            p_press = 1'b0;
            exp_q.delete();
        end else begin
            if (evt_valid) chk("busy_with_valid", {31'd0, busy}, 32'd1);
            if (p_valid && !p_ready) chk("stall_valid", {31'd0, evt_valid}, 32'd1);
            if (evt_valid && (!p_valid || p_ready)) begin
                // A new event must be a real change that was stable for the window.
                chk("evt_is_change", {31'd0, evt_press}, {31'd0, ~m_btn[evt_id]});
                for (int k = 2; k <= D + 2; k++)
                    chk("debounced", {31'd0, hist[k][evt_id]}, {31'd0, evt_press});
                m_btn[evt_id] = evt_press;
            end else if (evt_valid && p_valid && !p_ready) begin
                chk("stall_id", {29'd0, evt_id}, {29'd0, p_id});
                chk("stall_press", {31'd0, evt_press}, {31'd0, p_press});
            end
            chk("button", {24'd0, button}, {24'd0, m_btn});
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: got id %0d press %0d, required none",
                             evt_id, evt_press);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_id", {29'd0, evt_id}, {29'd0, e.id});
                    chk("evt_press", {31'd0, evt_press}, {31'd0, e.press});
                end
            end
            p_valid = evt_valid;
            p_ready = evt_ready;
            p_id    = evt_id;
            p_press = evt_press;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int id, input logic press);
        ev_t e;
        e.id    = 3'(id);
        e.press = press;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (exp_q.size() == 0 && !evt_valid) break;
        end
        chk(name, {31'd0, (i < budget)}, 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_button"}, {24'd0, button}, 32'd0);
        chk({tag, "_valid"}, {31'd0, evt_valid}, 32'd0);
        chk({tag, "_id"}, {29'd0, evt_id}, 32'd0);
        chk({tag, "_press"}, {31'd0, evt_press}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cnt;
        #2 power = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) tick();
        power = 1'b1;
        repeat (3) tick();

        // Clean press on channel 3.
        expect_ev(3, 1'b1);
        bt[3] = 1'b1;
        cnt = 0;
        while (!evt_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("press_latency_le15", {31'd0, (cnt <= 15)}, 32'd1);
        tick();
        chk("valid_one_cycle", {31'd0, evt_valid}, 32'd0);
        chk("button_after_press", {24'd0, button}, 32'h08);
        repeat (10) tick();

        // Bounce on channel 5, then settle high.
        expect_ev(5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bt[5] = ~i[0];
            repeat (2) tick();
        end
        bt[5] = 1'b1;
        wait_drain("bounce_drain", 40);
        chk("button_after_bounce", {24'd0, button}, 32'h28);

        // Backpressure: channel 1 held in WAIT_ACK, channel 2 arrives during stall.
        expect_ev(1, 1'b1);
        expect_ev(2, 1'b1);
        evt_ready = 1'b0;
        bt[1] = 1'b1;
        cnt = 0;
        while (!evt_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("stall_reached", {31'd0, evt_valid}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) bt[2] = 1'b1;
            tick();
        end
        chk("stall_no_commit2", {31'd0, button[2]}, 32'd0);
        evt_ready = 1'b1;
        wait_drain("stall_drain", 40);
        chk("button_after_stall", {24'd0, button}, 32'h2E);

        // Commit channel 0, then reset in the middle of channel 6 timing.
        expect_ev(0, 1'b1);
        bt[0] = 1'b1;
        wait_drain("ch0_drain", 40);
        bt[6] = 1'b1;
        cnt = 0;
        while (!busy && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("ch6_timing", {31'd0, busy}, 32'd1);
        tick();
        #2 power = 1'b0;
        #1 check_outputs_zero("async_reset");
        repeat (2) tick();
        power = 1'b1;
        // Scan resumes at 0 but sees the synced levels only when ptr reaches 2.
        expect_ev(2, 1'b1);
        expect_ev(3, 1'b1);
        expect_ev(5, 1'b1);
        expect_ev(6, 1'b1);
        expect_ev(0, 1'b1);
        expect_ev(1, 1'b1);
        wait_drain("redetect_drain", 80);
        chk("button_after_redetect", {24'd0, button}, 32'h6F);
        expect_ev(0, 1'b0);
        bt[0] = 1'b0;
        wait_drain("release_drain", 40);
        chk("button_after_release", {24'd0, button}, 32'h6E);

        // Simultaneous press with ptr at 0 when the new levels reach the scanner.
        bt = '0;
        tick();
        #2 power = 1'b0;
        repeat (2) tick();
        power = 1'b1;
        repeat (6) tick();
        for (int i = 0; i < 8; i++) expect_ev(i, 1'b1);
        bt = 8'hFF;
        wait_drain("simul_drain", 120);
        chk("button_all", {24'd0, button}, 32'hFF);

        // Default window: detection to event is 51 cycles.
        bt50[0] = 1'b1;
        cnt = 0;
        while (!busy50 && cnt < 20) begin
            tick();
            cnt++;
        end
        cnt = 0;
        while (!evt_valid50 && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("latency50", cnt, 32'd51);
        chk("ev50_id", {29'd0, evt_id50}, 32'd0);
        chk("ev50_press", {31'd0, evt_press50}, 32'd1);
        chk("button50", {24'd0, button50}, 32'h01);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
